// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register command sequencer.
// Mode codes match the register's select encoding.
package usr_pkg;

  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_ROL  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer driving a 4-bit universal shift register:
// one handshaked command in, N register operations, one response out.
module usr_cmd_sequencer #(
  parameter int CNT_W = usr_pkg::CNT_W_DEF,
  parameter int SD_W  = 2**CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [SD_W-1:0]  cmd_sdata,
  output logic [1:0]       usr_s,
  output logic [3:0]       usr_pdata,
  output logic             usr_sin,
  input  logic [3:0]       usr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic             busy
);

  import usr_pkg::*;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [SD_W-1:0]  sdata_q, sdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_cnt;
  logic [3:0]       pdata_q, pdata_d;
  logic             sin_q, sin_d;
  logic [3:0]       rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= MODE_HOLD;
      sdata_q  <= '0;
      cnt_q    <= '0;
      pdata_q  <= '0;
      sin_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sdata_q  <= sdata_d;
      cnt_q    <= cnt_d;
      pdata_q  <= pdata_d;
      sin_q    <= sin_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // sdata_q holds the not-yet-used serial bits, bit 0 = next shift
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sdata_d  = sdata_q;
    cnt_d    = cnt_q;
    pdata_d  = pdata_q;
    sin_d    = sin_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    n_cnt    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          n_cnt   = (cmd_op == MODE_LOAD) ? CNT_W'(1) : cmd_count;
          op_d    = cmd_op;
          sdata_d = cmd_sdata >> 1;
          cnt_d   = n_cnt;
          if (cmd_op == MODE_LOAD)
            pdata_d = cmd_data;
          if (n_cnt != '0) begin
            state_d = ST_RUN;
            sin_d   = (cmd_op == MODE_SHR) && cmd_sdata[0];
          end else begin
            state_d  = ST_RESP;
            sin_d    = 1'b0;
            rdata_d  = usr_q;
            rvalid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = ST_RESP;
          cnt_d    = '0;
          sin_d    = 1'b0;
          rdata_d  = usr_q;
          rvalid_d = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          sin_d   = (op_q == MODE_SHR) && sdata_q[0];
          sdata_d = sdata_q >> 1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        rvalid_d = 1'b0;
        sin_d    = 1'b0;
      end
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign usr_s     = (state_q == ST_RUN) ? op_q : MODE_HOLD;
  assign usr_pdata = pdata_q;
  assign usr_sin   = sin_q;
  assign rsp_valid = rvalid_q;
  assign rsp_data  = rdata_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Sequencer bench with a behavioural universal shift register as load.
// Results are checked against a command-level reference model.
module tb_usr_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_data = 4'h0;
  logic [3:0]  cmd_count = 4'h0;
  logic [15:0] cmd_sdata = 16'h0;
  logic [1:0]  usr_s;
  logic [3:0]  usr_pdata;
  logic        usr_sin;
  logic [3:0]  usr_q = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] mq = 4'h0;

  usr_cmd_sequencer #(.CNT_W(4), .SD_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_count(cmd_count), .cmd_sdata(cmd_sdata),
    .usr_s(usr_s), .usr_pdata(usr_pdata),
    .usr_sin(usr_sin), .usr_q(usr_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // shift register load, captures on negedge
  always @(negedge clk) begin
    case (usr_s)
      2'b00: usr_q <= usr_pdata;
      2'b01: usr_q <= {usr_sin, usr_q[3:1]};
      2'b10: usr_q <= {usr_q[2:0], usr_q[3]};
      default: usr_q <= usr_q;
    endcase
  end

  function automatic logic [3:0] ref_q(input logic [3:0] q0,
                                       input logic [1:0] op,
                                       input logic [3:0] d,
                                       input logic [3:0] c,
                                       input logic [15:0] sd);
    logic [3:0] r;
    r = q0;
    case (op)
      2'b00: r = d;
      2'b01: for (int j = 0; j < int'(c); j++) r = {sd[j], r[3:1]};
      2'b10: for (int j = 0; j < int'(c); j++) r = {r[2:0], r[3]};
      default: r = q0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [3:0] c);
    return (op == 2'b00) ? 1 : int'(c);
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] d,
                         input logic [3:0] c, input logic [15:0] sd,
                         output int lat, output logic [3:0] rd,
                         output bit tr);
    int k;
    logic exp_sin;
    tr = 1'b1;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 30) begin
      @(posedge clk); #1; k++;
    end
    cmd_valid = 1'b1;
    cmd_op = op; cmd_data = d; cmd_count = c; cmd_sdata = sd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_data = 4'($urandom);
    cmd_count = 4'($urandom); cmd_sdata = 16'($urandom);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      exp_sin = (op == 2'b01 && lat < 16) ? sd[lat] : 1'b0;
      if (usr_s !== op || cmd_ready !== 1'b0 || busy !== 1'b1 ||
          usr_sin !== exp_sin)
        tr = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (rsp_valid !== 1'b1) lat = -1;
    if (usr_s !== 2'b11 || usr_sin !== 1'b0) tr = 1'b0;
    rd = rsp_data;
  endtask

  task automatic finish_rsp(input int stall, output bit stable,
                            output bit rdy);
    logic [3:0] rd0;
    rd0 = rsp_data;
    stable = 1'b1;
    rsp_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== rd0 ||
          cmd_ready !== 1'b0 || usr_s !== 2'b11 || busy !== 1'b1)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    rdy = (cmd_ready === 1'b1) && (rsp_valid === 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    n_cmp++;
    if ({usr_s, usr_pdata, usr_sin, rsp_valid, rsp_data, busy, cmd_ready}
        !== {2'b11, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: s=%b pd=%h sin=%b rv=%b rd=%h busy=%b rdy=%b required s=11 pd=0 sin=0 rv=0 rd=0 busy=0 rdy=1",
               usr_s, usr_pdata, usr_sin, rsp_valid, rsp_data, busy, cmd_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [15:0] sd;
    bit ok;
    sd = 16'($urandom);
    cmd_valid = 1'b1;
    cmd_op = 2'b01; cmd_count = 4'd10; cmd_sdata = sd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    mq = ref_q(mq, 2'b01, 4'h0, 4'd3, sd);
    n_cmp++;
    if (usr_s !== 2'b11 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_async: s=%b rv=%b busy=%b required s=11 rv=0 busy=0",
               usr_s, rsp_valid, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || usr_s !== 2'b11)
        ok = 1'b0;
    end
    n_cmp++;
    if (!ok || usr_q !== mq) begin
      n_bad++;
      $display("FAIL reset_mid_release: idle_ok=%0d q=%b required idle_ok=1 q=%b",
               ok, usr_q, mq);
    end
  endtask

  task automatic test_load;
    int lat; logic [3:0] rd; bit tr, st, rdy;
    run_cmd(2'b00, 4'b1010, 4'h7, 16'hFFFF, lat, rd, tr);
    finish_rsp(0, st, rdy);
    mq = ref_q(mq, 2'b00, 4'b1010, 4'h7, 16'hFFFF);
    n_cmp++;
    if (lat !== 1 || rd !== 4'b1010 || !tr || !rdy) begin
      n_bad++;
      $display("FAIL load: lat=%0d rd=%b trace=%0d rdy=%0d required lat=1 rd=1010 trace=1 rdy=1",
               lat, rd, tr, rdy);
    end
  endtask

  task automatic test_shr;
    int lat; logic [3:0] rd; bit tr, st, rdy;
    run_cmd(2'b00, 4'b0000, 4'h0, 16'h0, lat, rd, tr);
    finish_rsp(0, st, rdy);
    mq = ref_q(mq, 2'b00, 4'b0000, 4'h0, 16'h0);
    run_cmd(2'b01, 4'hF, 4'd4, 16'h0006, lat, rd, tr);
    finish_rsp(0, st, rdy);
    mq = ref_q(mq, 2'b01, 4'hF, 4'd4, 16'h0006);
    n_cmp++;
    if (lat !== 4 || rd !== 4'b0110 || rd !== mq || !tr || !rdy) begin
      n_bad++;
      $display("FAIL shr4: lat=%0d rd=%b trace=%0d rdy=%0d required lat=4 rd=0110 trace=1 rdy=1",
               lat, rd, tr, rdy);
    end
  endtask

  task automatic test_rol;
    int lat; logic [3:0] rd; bit tr, st, rdy;
    run_cmd(2'b00, 4'b1000, 4'h0, 16'h0, lat, rd, tr);
    finish_rsp(0, st, rdy);
    run_cmd(2'b10, 4'h0, 4'd1, 16'h0, lat, rd, tr);
    finish_rsp(0, st, rdy);
    n_cmp++;
    if (lat !== 1 || rd !== 4'b0001 || !tr) begin
      n_bad++;
      $display("FAIL rol1: lat=%0d rd=%b trace=%0d required lat=1 rd=0001 trace=1",
               lat, rd, tr);
    end
    run_cmd(2'b00, 4'b1010, 4'h0, 16'h0, lat, rd, tr);
    finish_rsp(0, st, rdy);
    run_cmd(2'b10, 4'h0, 4'd5, 16'h0, lat, rd, tr);
    finish_rsp(0, st, rdy);
    mq = ref_q(4'b1010, 2'b10, 4'h0, 4'd5, 16'h0);
    n_cmp++;
    if (lat !== 5 || rd !== 4'b0101 || rd !== mq || !tr) begin
      n_bad++;
      $display("FAIL rol5: lat=%0d rd=%b trace=%0d required lat=5 rd=0101 trace=1",
               lat, rd, tr);
    end
  endtask

  task automatic test_zero_count;
    int lat; logic [3:0] rd; bit tr, st, rdy;
    logic [1:0] ops [3];
    ops[0] = 2'b01; ops[1] = 2'b10; ops[2] = 2'b11;
    foreach (ops[i]) begin
      run_cmd(2'b00, 4'b1100, 4'h0, 16'h0, lat, rd, tr);
      finish_rsp(0, st, rdy);
      run_cmd(ops[i], 4'h3, 4'd0, 16'hFFFF, lat, rd, tr);
      finish_rsp(1, st, rdy);
      mq = 4'b1100;
      n_cmp++;
      if (lat !== 0 || rd !== 4'b1100 || usr_q !== 4'b1100 || !tr || !st || !rdy) begin
        n_bad++;
        $display("FAIL zero_count op=%b: lat=%0d rd=%b q=%b trace=%0d stable=%0d rdy=%0d required lat=0 rd=1100 q=1100 trace=1 stable=1 rdy=1",
                 ops[i], lat, rd, usr_q, tr, st, rdy);
      end
    end
  endtask

  task automatic test_stall;
    int lat; logic [3:0] rd; bit tr, st, rdy;
    logic [3:0] d;
    d = 4'($urandom);
    run_cmd(2'b00, d, 4'h0, 16'h0, lat, rd, tr);
    finish_rsp(7, st, rdy);
    mq = d;
    n_cmp++;
    if (rd !== d || !st || !rdy || !tr) begin
      n_bad++;
      $display("FAIL stall7: rd=%b stable=%0d rdy=%0d trace=%0d required rd=%b stable=1 rdy=1 trace=1",
               rd, st, rdy, tr, d);
    end
  endtask

  task automatic test_random;
    int lat, elat; logic [3:0] rd, eq; bit tr, st, rdy;
    logic [1:0] op; logic [3:0] d, c; logic [15:0] sd;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); d = 4'($urandom);
      c = 4'($urandom); sd = 16'($urandom);
      if (i % 8 == 0) c = 4'd15;
      run_cmd(op, d, c, sd, lat, rd, tr);
      finish_rsp(int'($urandom_range(0, 3)), st, rdy);
      eq = ref_q(mq, op, d, c, sd);
      elat = ref_lat(op, c);
      mq = eq;
      n_cmp++;
      if (lat !== elat || rd !== eq || !tr || !st || !rdy) begin
        n_bad++;
        $display("FAIL random[%0d] op=%b c=%0d: lat=%0d rd=%b trace=%0d stable=%0d rdy=%0d required lat=%0d rd=%b trace=1 stable=1 rdy=1",
                 i, op, c, lat, rd, tr, st, rdy, elat, eq);
      end
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_reset_mid;
    test_load;
    test_shr;
    test_rol;
    test_zero_count;
    test_stall;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
